// File: rtl/if_stage_pkg.sv
// Shared constants and FSM encoding for the ONC-16 instruction-fetch stage.
package if_stage_pkg;

  localparam int IF_INST_W   = 16;
  localparam int IF_ADDR_W   = 16;
  localparam int IF_DEPTH    = 2;
  localparam int IF_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } if_state_e;

endpackage

// File: rtl/if_stage_fifo.sv
// Small synchronous queue of fetched {pc, instruction} pairs; flush wins over push/pop.
module if_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       n_rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wdata;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, keeps one imem read in flight and queues results for ID.
//   state | meaning
//   IDLE  | nothing outstanding at instruction memory
//   WAIT  | one request outstanding; its response is pushed to the queue
//   DROP  | one request outstanding whose response must be discarded (post-redirect)
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                INST_W   = IF_INST_W,
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                DEPTH    = IF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  input  logic              id_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  if_state_e           state_q;
  logic [ADDR_W-1:0]   fetch_pc_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                started_q;

  logic                push;
  logic                pop;
  logic                credit;
  logic                issue;
  logic [CW-1:0]       count;
  logic [CW:0]         occ_next;
  logic [ADDR_W+INST_W-1:0] fifo_rdata;

  assign push = !redirect && (state_q == ST_WAIT) && imem_rvalid;
  assign pop  = !redirect && id_valid && id_ready;

  // Occupancy after this cycle's push/pop; issuing is allowed only if the reply will fit.
  assign occ_next = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, push};
  assign credit   = occ_next < (CW+1)'(DEPTH);

  // started_q keeps imem_req low while reset is held and until the first clock after release.
  assign issue = started_q && !redirect && credit &&
                 ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && imem_rvalid));

  assign imem_req  = issue;
  assign imem_addr = issue ? fetch_pc_q : '0;

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      started_q  <= 1'b0;
    end else begin
      started_q <= 1'b1;
      if (redirect) begin
        fetch_pc_q <= redirect_pc;
        state_q    <= ((state_q != ST_IDLE) && !imem_rvalid) ? ST_DROP : ST_IDLE;
      end else begin
        if (issue) begin
          fetch_pc_q <= fetch_pc_q + 1'b1;
          addr_q     <= fetch_pc_q;
        end
        case (state_q)
          ST_IDLE: if (issue) state_q <= ST_WAIT;
          ST_WAIT: if (imem_rvalid) state_q <= issue ? ST_WAIT : ST_IDLE;
          ST_DROP: if (imem_rvalid) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  if_fifo #(
    .W     (ADDR_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .n_rst (n_rst),
    .flush (redirect),
    .push  (push),
    .pop   (pop),
    .wdata ({addr_q, imem_rdata}),
    .rdata (fifo_rdata),
    .count (count)
  );

  assign {id_pc, id_inst} = fifo_rdata;
  assign id_valid         = (count != '0);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cycle table for streaming/stall/redirect/wrap, then latency and reset sequences.
module tb_if_stage;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam int   NV = 26;

  logic        clock = 1'b0;
  logic        n_rst = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        id_valid;
  logic [15:0] id_inst;
  logic [15:0] id_pc;
  logic        id_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rd;
    logic [15:0] rpc;
    logic        rv;
    logic [15:0] rdat;
    logic        rdy;
    logic        ereq;
    logic [15:0] eaddr;
    logic        eval;
    logic [15:0] epc;
    logic [15:0] einst;
  } vec_t;

  vec_t tv [NV];

  if_stage dut (
    .clock       (clock),
    .n_rst       (n_rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_ready    (id_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Holds reset for a few cycles, checks reset outputs, releases just after a rising edge.
  task automatic do_reset();
    n_rst = 1'b0;
    redirect = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    id_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst imem_req", 16'(imem_req), 16'h0);
    chk("rst imem_addr", imem_addr, 16'h0);
    chk("rst id_valid", 16'(id_valid), 16'h0);
    chk("rst id_inst", id_inst, 16'h0);
    chk("rst id_pc", id_pc, 16'h0);
    @(posedge clock);
    #1 n_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          pend;
    int          dly;
    int          last_req;
    logic [15:0] paddr;
    logic [15:0] exp_addr;
    logic [15:0] next_pc;

    // rd rpc rv rdat rdy | ereq eaddr eval epc einst ; memory returns addr+0x1000
    tv[0]  = '{N,16'h0000,N,16'h0000,Y, N,16'h0000, N,16'h0000,16'h0000};
    tv[1]  = '{N,16'h0000,N,16'h0000,Y, Y,16'h0000, N,16'h0000,16'h0000};
    tv[2]  = '{N,16'h0000,Y,16'h1000,Y, Y,16'h0001, N,16'h0000,16'h0000};
    tv[3]  = '{N,16'h0000,Y,16'h1001,Y, Y,16'h0002, Y,16'h0000,16'h1000};
    tv[4]  = '{N,16'h0000,Y,16'h1002,Y, Y,16'h0003, Y,16'h0001,16'h1001};
    tv[5]  = '{N,16'h0000,Y,16'h1003,N, N,16'h0000, Y,16'h0002,16'h1002};
    tv[6]  = '{N,16'h0000,N,16'h0000,N, N,16'h0000, Y,16'h0002,16'h1002};
    tv[7]  = '{N,16'h0000,N,16'h0000,N, N,16'h0000, Y,16'h0002,16'h1002};
    tv[8]  = '{N,16'h0000,N,16'h0000,N, N,16'h0000, Y,16'h0002,16'h1002};
    tv[9]  = '{N,16'h0000,N,16'h0000,N, N,16'h0000, Y,16'h0002,16'h1002};
    tv[10] = '{N,16'h0000,N,16'h0000,Y, Y,16'h0004, Y,16'h0002,16'h1002};
    tv[11] = '{N,16'h0000,Y,16'h1004,Y, Y,16'h0005, Y,16'h0003,16'h1003};
    tv[12] = '{N,16'h0000,Y,16'h1005,Y, Y,16'h0006, Y,16'h0004,16'h1004};
    tv[13] = '{N,16'h0000,N,16'h0000,Y, N,16'h0000, Y,16'h0005,16'h1005};
    tv[14] = '{Y,16'h0040,N,16'h0000,Y, N,16'h0000, N,16'h0000,16'h0000};
    tv[15] = '{N,16'h0000,N,16'h0000,Y, N,16'h0000, N,16'h0000,16'h0000};
    tv[16] = '{N,16'h0000,Y,16'hDEAD,Y, N,16'h0000, N,16'h0000,16'h0000};
    tv[17] = '{N,16'h0000,N,16'h0000,Y, Y,16'h0040, N,16'h0000,16'h0000};
    tv[18] = '{N,16'h0000,Y,16'h1040,Y, Y,16'h0041, N,16'h0000,16'h0000};
    tv[19] = '{N,16'h0000,Y,16'h1041,Y, Y,16'h0042, Y,16'h0040,16'h1040};
    tv[20] = '{Y,16'hFFFF,Y,16'h1042,Y, N,16'h0000, Y,16'h0041,16'h1041};
    tv[21] = '{N,16'h0000,N,16'h0000,Y, Y,16'hFFFF, N,16'h0000,16'h0000};
    tv[22] = '{N,16'h0000,Y,16'h0FFF,Y, Y,16'h0000, N,16'h0000,16'h0000};
    tv[23] = '{N,16'h0000,Y,16'h1000,Y, Y,16'h0001, Y,16'hFFFF,16'h0FFF};
    tv[24] = '{N,16'h0000,N,16'h0000,N, N,16'h0000, Y,16'h0000,16'h1000};
    tv[25] = '{N,16'h0000,N,16'h0000,N, N,16'h0000, Y,16'h0000,16'h1000};

    do_reset();
    for (int i = 0; i < NV; i++) begin
      redirect    = tv[i].rd;
      redirect_pc = tv[i].rpc;
      imem_rvalid = tv[i].rv;
      imem_rdata  = tv[i].rdat;
      id_ready    = tv[i].rdy;
      @(negedge clock);
      chk($sformatf("row%0d imem_req", i), 16'(imem_req), 16'(tv[i].ereq));
      chk($sformatf("row%0d imem_addr", i), imem_addr, tv[i].eaddr);
      chk($sformatf("row%0d id_valid", i), 16'(id_valid), 16'(tv[i].eval));
      if (tv[i].eval) begin
        chk($sformatf("row%0d id_pc", i), id_pc, tv[i].epc);
        chk($sformatf("row%0d id_inst", i), id_inst, tv[i].einst);
      end
      @(posedge clock);
      #1;
    end

    // Slow memory: response four cycles after the request (three dead cycles).
    do_reset();
    pend = 1'b0;
    dly = 0;
    last_req = -1;
    paddr = '0;
    exp_addr = '0;
    next_pc = '0;
    for (int c = 0; c < 40; c++) begin
      imem_rvalid = 1'b0;
      if (pend) begin
        dly--;
        if (dly == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = paddr ^ 16'h5A00;
          pend = 1'b0;
        end
      end
      @(negedge clock);
      if (imem_req) begin
        chk($sformatf("lat cyc%0d req while outstanding", c), 16'(pend), 16'h0);
        chk($sformatf("lat cyc%0d imem_addr", c), imem_addr, exp_addr);
        if (last_req >= 0) chk($sformatf("lat cyc%0d req spacing", c), 16'(c - last_req), 16'd4);
        last_req = c;
        pend = 1'b1;
        dly = 4;
        paddr = imem_addr;
        exp_addr = exp_addr + 16'd1;
      end
      if (id_valid) begin
        chk($sformatf("lat cyc%0d id_pc", c), id_pc, next_pc);
        chk($sformatf("lat cyc%0d id_inst", c), id_inst, next_pc ^ 16'h5A00);
        next_pc = next_pc + 16'd1;
      end
      @(posedge clock);
      #1;
    end
    chk("lat instructions delivered", 16'(next_pc >= 16'd8), 16'h1);

    // Reset pulse while a request is outstanding; its late response must not reach ID.
    do_reset();
    @(negedge clock);
    chk("mrst c0 imem_req", 16'(imem_req), 16'h0);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("mrst c1 imem_req", 16'(imem_req), 16'h1);
    chk("mrst c1 imem_addr", imem_addr, 16'h0000);
    @(posedge clock);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 16'hBAD0;
    #1 n_rst = 1'b0;
    #2 n_rst = 1'b1;
    @(negedge clock);
    chk("mrst c2 imem_req", 16'(imem_req), 16'h0);
    chk("mrst c2 id_valid", 16'(id_valid), 16'h0);
    @(posedge clock);
    #1;
    imem_rvalid = 1'b0;
    @(negedge clock);
    chk("mrst c3 id_valid", 16'(id_valid), 16'h0);
    chk("mrst c3 imem_req", 16'(imem_req), 16'h1);
    chk("mrst c3 imem_addr", imem_addr, 16'h0000);
    @(posedge clock);
    #1;
    imem_rvalid = 1'b1;
    imem_rdata  = 16'h5A00;
    @(negedge clock);
    chk("mrst c4 id_valid", 16'(id_valid), 16'h0);
    chk("mrst c4 imem_addr", imem_addr, 16'h0001);
    @(posedge clock);
    #1;
    imem_rdata = 16'h5A01;
    @(negedge clock);
    chk("mrst c5 id_valid", 16'(id_valid), 16'h1);
    chk("mrst c5 id_pc", id_pc, 16'h0000);
    chk("mrst c5 id_inst", id_inst, 16'h5A00);
    @(posedge clock);
    #1;
    imem_rvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
